vproc_unit_sched: RTL and testbench

In-order result scheduler for the vector functional units. It records, in dispatch order, which unit each instruction was issued to. It grants the shared result/writeback path only to the unit owning the oldest outstanding instruction, and holds that grant until the unit's last beat is accepted. It sits between the unit array and the writeback stage and replaces free-running first-valid-wins output selection.

---
 rtl/vproc_unit_sched.sv | 129 ++++++++++++
 tb/tb_vproc_unit_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vproc_unit_sched.sv
// In-order result scheduler: grants the shared writeback path to the unit owning the oldest
// outstanding instruction. Define VPROC_UNIT_SCHED_PERF_EN to enable the stall counter.
package vproc_pkg;
  parameter int unsigned UNIT_CNT = 8;
endpackage

module vproc_unit_sched #(
  parameter logic [vproc_pkg::UNIT_CNT-1:0] UNITS     = '0,
  parameter int unsigned                    XIF_ID_W  = 3,
  parameter int unsigned                    DEPTH     = 4,
  parameter int unsigned                    PAYLOAD_W = 64,
  localparam int unsigned UNIT_CNT = vproc_pkg::UNIT_CNT,
  localparam int unsigned UNIT_W   = $clog2(UNIT_CNT),
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                            clk_i,
  input  logic                            async_rst_ni,
  input  logic                            disp_valid_i,
  output logic                            disp_ready_o,
  input  logic [UNIT_W-1:0]               disp_unit_i,
  input  logic [XIF_ID_W-1:0]             disp_id_i,
  output logic                            disp_illegal_o,
  input  logic [UNIT_CNT-1:0]             unit_valid_i,
  output logic [UNIT_CNT-1:0]             unit_ready_o,
  input  logic [UNIT_CNT-1:0]             unit_last_i,
  input  logic [UNIT_CNT*XIF_ID_W-1:0]    unit_id_i,
  input  logic [UNIT_CNT*PAYLOAD_W-1:0]   unit_payload_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            out_last_o,
  output logic [XIF_ID_W-1:0]             out_id_o,
  output logic [UNIT_W-1:0]               out_unit_o,
  output logic [PAYLOAD_W-1:0]            out_payload_o,
  output logic                            id_mismatch_o,
  output logic                            fifo_empty_o,
  output logic [31:0]                     stall_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [UNIT_W-1:0]   unit;
    logic [XIF_ID_W-1:0] id;
  } entry_t;

  entry_t             r_fifo [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  entry_t             w_head;
  logic               w_empty;
  logic               w_unit_ok;
  logic               w_push;
  logic               w_pop;
  logic               w_beat_valid;
  logic               w_beat_last;
  logic [XIF_ID_W-1:0]  w_beat_id;
  logic [PAYLOAD_W-1:0] w_beat_payload;

  assign w_empty      = (r_count == '0);
  assign fifo_empty_o = w_empty;
  // Only the registered count decides readiness, so a same-cycle pop never frees a slot.
  assign disp_ready_o = (r_count != CNT_W'(DEPTH));

  assign w_unit_ok      = UNITS[disp_unit_i];
  assign w_push         = disp_valid_i & disp_ready_o & w_unit_ok;
  assign disp_illegal_o = disp_valid_i & disp_ready_o & ~w_unit_ok;

  assign w_head         = r_fifo[r_rd_ptr];
  assign w_beat_valid   = unit_valid_i[w_head.unit];
  assign w_beat_last    = unit_last_i[w_head.unit];
  assign w_beat_id      = unit_id_i[w_head.unit*XIF_ID_W +: XIF_ID_W];
  assign w_beat_payload = unit_payload_i[w_head.unit*PAYLOAD_W +: PAYLOAD_W];

  assign out_valid_o   = ~w_empty & w_beat_valid;
  assign out_unit_o    = w_head.unit;
  assign out_last_o    = out_valid_o & w_beat_last;
  assign out_id_o      = out_valid_o ? w_beat_id : '0;
  assign out_payload_o = out_valid_o ? w_beat_payload : '0;
  assign id_mismatch_o = out_valid_o & (w_beat_id != w_head.id);

  always_comb begin
    unit_ready_o = '0;
    if (!w_empty) unit_ready_o[w_head.unit] = out_ready_i;
  end

  assign w_pop = out_valid_o & out_ready_i & out_last_o;

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= '{unit: disp_unit_i, id: disp_id_i};
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef VPROC_UNIT_SCHED_PERF_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = |(UNITS & unit_valid_i & ~unit_ready_o);

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vproc_unit_sched.sv
// Directed bench for vproc_unit_sched: per-cycle vector table plus hand-written reset/stall sequences.
module tb_vproc_unit_sched;

  localparam int UC = vproc_pkg::UNIT_CNT;  // 8 units, 3-bit unit index

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 disp_valid;
  logic                 disp_ready;
  logic [2:0]           disp_unit;
  logic [2:0]           disp_id;
  logic                 disp_illegal;
  logic [UC-1:0]        unit_valid;
  logic [UC-1:0]        unit_ready;
  logic [UC-1:0]        unit_last;
  logic [UC*3-1:0]      unit_id;
  logic [UC*64-1:0]     unit_payload;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [2:0]           out_id;
  logic [2:0]           out_unit;
  logic [63:0]          out_payload;
  logic                 id_mismatch;
  logic                 fifo_empty;
  logic [31:0]          stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vproc_unit_sched #(
    .UNITS     (8'b0000_1111),
    .XIF_ID_W  (3),
    .DEPTH     (4),
    .PAYLOAD_W (64)
  ) dut (
    .clk_i          (clk),
    .async_rst_ni   (rst_n),
    .disp_valid_i   (disp_valid),
    .disp_ready_o   (disp_ready),
    .disp_unit_i    (disp_unit),
    .disp_id_i      (disp_id),
    .disp_illegal_o (disp_illegal),
    .unit_valid_i   (unit_valid),
    .unit_ready_o   (unit_ready),
    .unit_last_i    (unit_last),
    .unit_id_i      (unit_id),
    .unit_payload_i (unit_payload),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_last_o     (out_last),
    .out_id_o       (out_id),
    .out_unit_o     (out_unit),
    .out_payload_o  (out_payload),
    .id_mismatch_o  (id_mismatch),
    .fifo_empty_o   (fifo_empty),
    .stall_cnt_o    (stall_cnt)
  );

  typedef struct {
    logic       dv;
    logic [2:0] du;
    logic [2:0] did;
    logic [7:0] uv;
    logic [7:0] ul;
    logic [2:0] uid;
    logic       ordy;
    logic       e_drdy;
    logic       e_ill;
    logic       e_ov;
    logic [7:0] e_urdy;
    logic       e_last;
    logic [2:0] e_id;
    logic [2:0] e_unit;
    logic       e_mism;
    logic       e_empty;
  } vec_t;

  vec_t vecs [64];
  int   nv = 0;

  function automatic logic [63:0] pay(input int u);
    logic [31:0] uu;
    uu = 32'(u);
    return {32'hC0DE_0000 + uu, 32'h1234_5670 + uu};
  endfunction

  task automatic add(input vec_t t);
    vecs[nv] = t;
    nv++;
  endtask

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (step %0d): got %h expected %h", nm, k, act, exp);
    end
  endtask

  task automatic set_ids(input logic [2:0] id);
    for (int u = 0; u < UC; u++) unit_id[u*3 +: 3] = id;
  endtask

  initial begin
    rst_n = 1'b0;
    disp_valid = 1'b0; disp_unit = '0; disp_id = '0;
    unit_valid = '0; unit_last = '0; unit_id = '0; out_ready = 1'b0;
    for (int u = 0; u < UC; u++) unit_payload[u*64 +: 64] = pay(u);

    // Order: dv du did uv ul uid ordy | drdy ill ov urdy last id unit mism empty
    add('{0,0,0,8'h00,8'h00,0,1, 1,0,0,8'h00,0,0,0,0,1});  // idle
    add('{1,2,3,8'h00,8'h00,0,1, 1,0,0,8'h00,0,0,0,0,1});  // id3 -> unit2
    add('{1,1,4,8'h02,8'h00,4,1, 1,0,0,8'h04,0,0,2,0,0});  // id4 -> unit1, unit1 early valid blocked
    add('{0,0,0,8'h06,8'h00,3,0, 1,0,1,8'h00,0,3,2,0,0});  // writeback not ready
    add('{0,0,0,8'h06,8'h00,3,1, 1,0,1,8'h04,0,3,2,0,0});  // beat 1
    add('{0,0,0,8'h06,8'h00,3,1, 1,0,1,8'h04,0,3,2,0,0});  // beat 2
    add('{0,0,0,8'h06,8'h04,3,1, 1,0,1,8'h04,1,3,2,0,0});  // beat 3, last
    add('{0,0,0,8'h02,8'h02,4,1, 1,0,1,8'h02,1,4,1,0,0});  // unit1 granted next cycle
    add('{0,0,0,8'h00,8'h00,0,1, 1,0,0,8'h00,0,0,0,0,1});  // drained
    add('{1,0,0,8'h00,8'h00,0,1, 1,0,0,8'h00,0,0,0,0,1});  // fill 1
    add('{1,1,1,8'h00,8'h00,0,1, 1,0,0,8'h01,0,0,0,0,0});  // fill 2
    add('{1,2,2,8'h00,8'h00,0,1, 1,0,0,8'h01,0,0,0,0,0});  // fill 3
    add('{1,3,3,8'h00,8'h00,0,1, 1,0,0,8'h01,0,0,0,0,0});  // fill 4
    add('{1,0,7,8'h01,8'h01,0,1, 0,0,1,8'h01,1,0,0,0,0});  // full: pop accepted, push rejected
    add('{0,0,0,8'h00,8'h00,0,1, 1,0,0,8'h02,0,0,1,0,0});  // slot free again
    add('{0,0,0,8'h02,8'h02,1,1, 1,0,1,8'h02,1,1,1,0,0});
    add('{0,0,0,8'h04,8'h04,2,1, 1,0,1,8'h04,1,2,2,0,0});
    add('{0,0,0,8'h08,8'h08,3,1, 1,0,1,8'h08,1,3,3,0,0});
    add('{0,0,0,8'h00,8'h00,0,1, 1,0,0,8'h00,0,0,0,0,1});  // three pops emptied it: count was 3
    add('{1,5,6,8'h00,8'h00,0,1, 1,1,0,8'h00,0,0,0,0,1});  // unit5 not instantiated
    add('{0,0,0,8'h00,8'h00,0,1, 1,0,0,8'h00,0,0,0,0,1});  // still empty
    add('{1,0,5,8'h00,8'h00,0,1, 1,0,0,8'h00,0,0,0,0,1});  // id5 -> unit0
    add('{0,0,0,8'h01,8'h01,6,1, 1,0,1,8'h01,1,6,0,1,0});  // id mismatch, beat passes
    add('{0,0,0,8'h00,8'h00,0,1, 1,0,0,8'h00,0,0,0,0,1});

    #12;
    chk("rst_empty", -1, 64'(fifo_empty), 64'd1);
    chk("rst_drdy",  -1, 64'(disp_ready), 64'd1);
    chk("rst_ovalid",-1, 64'(out_valid),  64'd0);
    chk("rst_urdy",  -1, 64'(unit_ready), 64'd0);
    chk("rst_ill",   -1, 64'(disp_illegal), 64'd0);
    chk("rst_mism",  -1, 64'(id_mismatch), 64'd0);
    chk("rst_stall", -1, 64'(stall_cnt),  64'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < nv; k++) begin
      @(posedge clk); #1;
      disp_valid = vecs[k].dv;  disp_unit = vecs[k].du; disp_id = vecs[k].did;
      unit_valid = vecs[k].uv;  unit_last = vecs[k].ul; out_ready = vecs[k].ordy;
      set_ids(vecs[k].uid);
      #3;
      chk("disp_ready", k, 64'(disp_ready), 64'(vecs[k].e_drdy));
      chk("disp_illegal", k, 64'(disp_illegal), 64'(vecs[k].e_ill));
      chk("out_valid", k, 64'(out_valid), 64'(vecs[k].e_ov));
      chk("unit_ready", k, 64'(unit_ready), 64'(vecs[k].e_urdy));
      chk("out_last", k, 64'(out_last), 64'(vecs[k].e_last));
      chk("out_id", k, 64'(out_id), 64'(vecs[k].e_id));
      chk("id_mismatch", k, 64'(id_mismatch), 64'(vecs[k].e_mism));
      chk("fifo_empty", k, 64'(fifo_empty), 64'(vecs[k].e_empty));
      chk("out_payload", k, out_payload, vecs[k].e_ov ? pay(int'(vecs[k].e_unit)) : 64'd0);
      if (!vecs[k].e_empty) chk("out_unit", k, 64'(out_unit), 64'(vecs[k].e_unit));
    end

    // Stall counting and asynchronous reset in the middle of a burst.
    @(negedge clk) rst_n = 1'b0;
    disp_valid = 1'b0; unit_valid = '0; unit_last = '0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    disp_valid = 1'b1; disp_unit = 3'd3; disp_id = 3'd1;
    @(posedge clk); #1;
    disp_valid = 1'b0; unit_valid = 8'h09; unit_last = '0; set_ids(3'd1); out_ready = 1'b1;
    #1;
    chk("perf_ovalid", 100, 64'(out_valid), 64'd1);
    chk("perf_urdy", 100, 64'(unit_ready), 64'h08);
    repeat (10) @(posedge clk);
    #1;
`ifdef VPROC_UNIT_SCHED_PERF_EN
    chk("stall_cnt", 101, 64'(stall_cnt), 64'd10);
`else
    chk("stall_cnt", 101, 64'(stall_cnt), 64'd0);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("arst_empty", 102, 64'(fifo_empty), 64'd1);
    chk("arst_drdy", 102, 64'(disp_ready), 64'd1);
    chk("arst_ovalid", 102, 64'(out_valid), 64'd0);
    chk("arst_urdy", 102, 64'(unit_ready), 64'd0);
    chk("arst_ill", 102, 64'(disp_illegal), 64'd0);
    chk("arst_mism", 102, 64'(id_mismatch), 64'd0);
    chk("arst_stall", 102, 64'(stall_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ovalid", 103, 64'(out_valid), 64'd0);
    chk("post_rst_urdy", 103, 64'(unit_ready), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
